// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcode enum and datapath width for the ALU and MEM/WB stage
package cpu_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_ADDI  = 3'b001,
        OP_XOR   = 3'b010,
        OP_LOAD  = 3'b011,
        OP_STORE = 3'b100,
        OP_JUMP  = 3'b101,
        OP_CMP   = 3'b110,
        OP_SHF   = 3'b111
    } alu_op_e;

endpackage

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: register writeback, req/ack data-memory access, compare flag and jump redirect after the ALU
//   ex_*   : valid/ready instruction input from execute (op, result, zero, store data, rd)
//   dmem_* : request held until ack; rdata sampled on ack
//   wb_*   : one-cycle register-file write pulse
//   br_*   : one-cycle redirect pulse to fetch; cmp_flag is the live compare flag
module mem_wb_stage #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = 3,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [2:0]            ex_op,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_zero,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [MEM_ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  br_taken,
    output logic [DATA_W-1:0]     br_target,
    output logic                  cmp_flag
);
    import cpu_pkg::*;

    typedef enum logic [1:0] {IDLE, MEM, WB_LD} stage_e;

    stage_e                  state_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]       rdata_q;
    alu_op_e                 op;

    assign op       = alu_op_e'(ex_op);
    assign ex_ready = (state_q == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            rdata_q    <= '0;
            cmp_flag   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            br_taken   <= 1'b0;
            br_target  <= '0;
        end else begin
            wb_we    <= 1'b0;
            br_taken <= 1'b0;
            case (state_q)
                IDLE: if (ex_valid) begin
                    case (op)
                        OP_ADD, OP_ADDI, OP_XOR, OP_SHF: begin
                            wb_we   <= 1'b1;
                            wb_addr <= ex_rd;
                            wb_data <= ex_result;
                        end
                        OP_CMP: cmp_flag <= ex_zero;
                        OP_JUMP: if (cmp_flag) begin
                            br_taken  <= 1'b1;
                            br_target <= ex_result;
                        end
                        default: begin
                            state_q    <= MEM;
                            rd_q       <= ex_rd;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_STORE);
                            dmem_addr  <= ex_result[MEM_ADDR_W-1:0];
                            dmem_wdata <= ex_store_data;
                        end
                    endcase
                end
                MEM: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    rdata_q  <= dmem_rdata;
                    state_q  <= dmem_we ? IDLE : WB_LD;
                end
                default: begin
                    wb_we   <= 1'b1;
                    wb_addr <= rd_q;
                    wb_data <= rdata_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized instruction stream against a cycle-timeline reference model
module tb_mem_wb_stage;

    localparam int N = 2000;
    localparam int L = N + 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic       ex_ready;
    logic [2:0] ex_op;
    logic [7:0] ex_result;
    logic       ex_zero;
    logic [7:0] ex_store_data;
    logic [2:0] ex_rd;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ack;
    logic [7:0] dmem_rdata;
    logic       wb_we;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       br_taken;
    logic [7:0] br_target;
    logic       cmp_flag;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle activity, scheduled at accept time.
    logic       busy_e [L];
    logic       req_e  [L];
    logic       rwe_e  [L];
    logic [7:0] radr_e [L];
    logic [7:0] rwd_e  [L];
    logic       ack_at [L];
    logic [7:0] rdat   [L];
    logic       wb_e   [L];
    logic [2:0] wba_e  [L];
    logic [7:0] wbd_e  [L];
    logic       br_e   [L];
    logic [7:0] brt_e  [L];
    logic [7:0] mem    [256];
    logic       flag;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_result(ex_result),
        .ex_zero(ex_zero), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_taken(br_taken), .br_target(br_target), .cmp_flag(cmp_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ready"}, ex_ready, 1);
        check({tag, " req"}, dmem_req, 0);
        check({tag, " wb_we"}, wb_we, 0);
        check({tag, " br"}, br_taken, 0);
        check({tag, " flag"}, cmp_flag, 0);
    endtask

    initial begin
        int d;
        int lim;
        reset = 1'b1;
        ex_valid = 0; ex_op = 0; ex_result = 0; ex_zero = 0; ex_store_data = 0; ex_rd = 0;
        dmem_ack = 0; dmem_rdata = 0;
        flag = 0;
        for (int i = 0; i < L; i++) begin
            busy_e[i] = 0; req_e[i] = 0; rwe_e[i] = 0; radr_e[i] = 0; rwd_e[i] = 0;
            ack_at[i] = 0; rdat[i] = 0; wb_e[i] = 0; wba_e[i] = 0; wbd_e[i] = 0;
            br_e[i] = 0; brt_e[i] = 0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset we", dmem_we, 0);
        check("reset wbaddr", wb_addr, 0);
        check("reset wbdata", wb_data, 0);
        check("reset brt", br_target, 0);
        reset = 1'b0;

        for (int t = 0; t < N; t++) begin
            @(negedge clk);
            check("ready", ex_ready, !busy_e[t]);
            check("req", dmem_req, req_e[t]);
            if (req_e[t]) begin
                check("req we", dmem_we, rwe_e[t]);
                check("req addr", dmem_addr, radr_e[t]);
                check("req wdata", dmem_wdata, rwd_e[t]);
            end
            check("wb_we", wb_we, wb_e[t]);
            if (wb_e[t]) begin
                check("wb addr", wb_addr, wba_e[t]);
                check("wb data", wb_data, wbd_e[t]);
            end
            check("br", br_taken, br_e[t]);
            if (br_e[t]) check("br target", br_target, brt_e[t]);
            check("flag", cmp_flag, flag);
            // Drive this cycle; spurious acks only where no request is outstanding.
            ex_valid      = (t < N - 10) && ($urandom_range(0, 3) != 0);
            ex_op         = 3'($urandom);
            ex_result     = 8'($urandom);
            ex_zero       = 1'($urandom);
            ex_store_data = 8'($urandom);
            ex_rd         = 3'($urandom);
            dmem_ack      = ack_at[t] || (!req_e[t] && $urandom_range(0, 5) == 0);
            dmem_rdata    = ack_at[t] ? rdat[t] : 8'($urandom);
            if (ex_valid && !busy_e[t]) begin
                case (ex_op)
                    3'd0, 3'd1, 3'd2, 3'd7: begin
                        wb_e[t+1] = 1; wba_e[t+1] = ex_rd; wbd_e[t+1] = ex_result;
                    end
                    3'd6: flag = ex_zero;
                    3'd5: if (flag) begin
                        br_e[t+1] = 1; brt_e[t+1] = ex_result;
                    end
                    default: begin
                        d = $urandom_range(0, 3);
                        for (int k = 1; k <= d + 1; k++) begin
                            busy_e[t+k] = 1; req_e[t+k] = 1; rwe_e[t+k] = (ex_op == 3'd4);
                            radr_e[t+k] = ex_result; rwd_e[t+k] = ex_store_data;
                        end
                        ack_at[t+d+1] = 1;
                        if (ex_op == 3'd4) mem[ex_result] = ex_store_data;
                        else begin
                            rdat[t+d+1] = mem[ex_result];
                            busy_e[t+d+2] = 1;
                            wb_e[t+d+3] = 1; wba_e[t+d+3] = ex_rd; wbd_e[t+d+3] = mem[ex_result];
                        end
                    end
                endcase
            end
        end

        // Reset while a LOAD waits in MEM: access abandoned, never written back.
        ex_valid = 0; dmem_ack = 0;
        lim = 0;
        while (!ex_ready && lim < 10) begin
            @(negedge clk);
            lim++;
        end
        check("drain ready", ex_ready, 1);
        ex_valid = 1; ex_op = 3'd3; ex_result = 8'h20; ex_rd = 3'd5;
        @(negedge clk);
        ex_valid = 0;
        check("rst-mem req", dmem_req, 1);
        check("rst-mem ready", ex_ready, 0);
        reset = 1'b1;
        #1;
        check_idle_outputs("rst-mem");
        reset = 1'b0;
        dmem_ack = 1; dmem_rdata = 8'hA5;
        @(negedge clk);
        dmem_ack = 0;
        check_idle_outputs("post-rst");
        @(negedge clk);
        check_idle_outputs("post-rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
